tx_frame_arbiter: RTL
=====================

TX_FRAME_ARBITER -- requirements
Module: tx_frame_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, the AXI-stream data width.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, the byte-enable width.
REQ-003 SHALL have parameter USER_WIDTH, default 1, the tuser width.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, the per-port frame counter width.
REQ-005 SHALL use one clock, tx_clk; reset tx_rst is asynchronous and active-high.
REQ-006 tx_clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 tx_rst  input  1  asynchronous active-high reset.
REQ-008 s0_axis_tdata/tkeep/tvalid/tlast/tuser  input  DATA_WIDTH/KEEP_WIDTH/1/1/USER_WIDTH  requester 0 stream.
REQ-009 s0_axis_tready  output  1  requester 0 ready.
REQ-010 s1_axis_tdata/tkeep/tvalid/tlast/tuser  input  same widths  requester 1 stream.
REQ-011 s1_axis_tready  output  1  requester 1 ready.
REQ-012 m_axis_tdata/tkeep/tvalid/tlast/tuser  output  same widths  stream to the MAC tx_axis port.
REQ-013 m_axis_tready  input  1  MAC ready.
REQ-014 gap_cycles  input  8  idle cycles inserted after each frame.
REQ-015 grant  output  2  one-hot owner of m_axis; 2'b00 when none.
REQ-016 frame_count_0, frame_count_1  output  CNT_WIDTH  completed frames per port.
REQ-017 busy  output  1  high in GRANT or GAP state.

Function
REQ-018 SHALL implement states IDLE, GRANT, GAP.
REQ-019 IDLE: any sN_axis_tvalid high -> register grant, enter GRANT next cycle; no beat passes in the decision cycle.
REQ-020 Both valid in IDLE: round-robin picks the port not served last (without STRICT macro).
REQ-021 GRANT: m_axis_* = granted sN_axis_* combinationally; sN_axis_tready = m_axis_tready for granted port, 0 otherwise; zero data latency.
REQ-022 Outside GRANT: m_axis_tvalid = 0, both tready = 0, m_axis data fields 0.
REQ-023 Frame end = m_axis_tvalid & m_axis_tready & m_axis_tlast; SHALL increment that port's counter and update last-served pointer the same edge.
REQ-024 Frame end: gap_cycles sampled; 0 -> IDLE, else GAP loading counter with gap_cycles.
REQ-025 GAP: counter decrements each cycle; leave to IDLE the cycle it reaches 1; GAP lasts exactly gap_cycles cycles.
REQ-026 Grant SHALL never change mid-frame, including while m_axis_tready is low.
REQ-027 Frame counters wrap from 2^CNT_WIDTH-1 to 0 without saturation.
REQ-028 Granted port dropping tvalid mid-frame holds GRANT; no timeout.

Reset
REQ-029 On tx_rst assertion, immediately: state IDLE, grant 0, busy 0, counters 0, gap counter 0, last-served = 1 (port 0 wins first tie).
REQ-030 Reset mid-frame aborts the frame; all tready/tvalid outputs 0 while tx_rst high.

Configuration
REQ-031 Macro TX_ARB_STRICT_PRIO_EN defined: in IDLE port 0 always wins when valid; pointer unused.
REQ-032 Macro undefined: round-robin per REQ-020.

Structure
REQ-033 Shared package eth_arb_pkg SHALL hold the state enum and port-index constants (PORT0, PORT1, NUM_PORTS=2).
REQ-034 Sub-module tx_arb_gap_counter (8-bit load/decrement/done) is natural; mux and FSM stay in the top.

Verification
REQ-035 Single port 0 frame, 3 beats, gap_cycles=0, m_axis_tready=1 -> grant=01 one cycle after tvalid, 3 beats pass unchanged, frame_count_0=1, IDLE next.
REQ-036 Both ports valid from reset, 1-beat frames, gap_cycles=0 -> grants 01,10,01,10; without macro counters equal after 4 frames.
REQ-037 Same as REQ-036 with TX_ARB_STRICT_PRIO_EN -> port 0 served all 4; frame_count_1=0.
REQ-038 gap_cycles=12 after 8-beat frame -> busy high, m_axis_tvalid low exactly 12 cycles, then IDLE.
REQ-039 m_axis_tready toggled low mid-frame with port 1 valid -> grant unchanged, no beat lost or duplicated.
REQ-040 tx_rst asserted on beat 2 of 4 -> grant=0, tready=0 immediately; frame_count_0=0 after release.

Source files
------------

// File: rtl/eth_arb_pkg.sv
// eth_arb_pkg
//   Shared definitions for the TX frame arbiter: the FSM state encoding and
//   the requester port indices / one-hot grant codes.
//   No ports (package).
package eth_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  localparam int PORT0     = 0;
  localparam int PORT1     = 1;
  localparam int NUM_PORTS = 2;

  localparam logic [NUM_PORTS-1:0] GRANT_NONE = 2'b00;
  localparam logic [NUM_PORTS-1:0] GRANT_P0   = 2'b01;
  localparam logic [NUM_PORTS-1:0] GRANT_P1   = 2'b10;

endpackage

// File: rtl/tx_arb_gap_counter.sv
// tx_arb_gap_counter
//   8-bit down-counter timing the inter-frame gap. Loaded with the gap length
//   when a frame ends, decremented once per gap cycle; done flags the final
//   gap cycle (terminal count of 1).
//   Ports:
//     tx_clk    in   clock
//     tx_rst    in   async active-high reset
//     load      in   load load_val this cycle
//     load_val  in   8  gap length
//     dec       in   decrement this cycle
//     done      out  counter is at 1 (last gap cycle)
module tx_arb_gap_counter (
  input  logic       tx_clk,
  input  logic       tx_rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic       done
);

  logic [7:0] count;

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign done = (count == 8'd1);

endmodule

// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter
//   Two-requester AXI-stream arbiter feeding a MAC transmit port. A whole frame
//   is granted to one requester; after each frame an optional idle gap of
//   gap_cycles cycles is inserted. Ties are broken round-robin, or with fixed
//   port-0 priority when TX_ARB_STRICT_PRIO_EN is defined.
//   Ports:
//     tx_clk, tx_rst                 clock, async active-high reset
//     s0_axis_*, s1_axis_*           requester streams (tready is an output)
//     m_axis_*                       stream to MAC (tready is an input)
//     gap_cycles        in   8       idle cycles after each frame
//     grant             out  2       one-hot owner of m_axis, 0 when none
//     frame_count_0/1   out  CNT_WIDTH  completed frames per port (wrapping)
//     busy              out  1       high in GRANT or GAP
//   Optional macro: TX_ARB_STRICT_PRIO_EN (port 0 always wins in IDLE).
//
//   state    | meaning
//   ST_IDLE  | no owner; pick a requester if any tvalid is high
//   ST_GRANT | granted port streams straight through to m_axis until tlast
//   ST_GAP   | post-frame idle gap, counted down by tx_arb_gap_counter
module tx_frame_arbiter
  import eth_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  tx_clk,
  input  logic                  tx_rst,

  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
  input  logic                  s0_axis_tvalid,
  input  logic                  s0_axis_tlast,
  input  logic [USER_WIDTH-1:0] s0_axis_tuser,
  output logic                  s0_axis_tready,

  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
  input  logic                  s1_axis_tvalid,
  input  logic                  s1_axis_tlast,
  input  logic [USER_WIDTH-1:0] s1_axis_tuser,
  output logic                  s1_axis_tready,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic                  m_axis_tready,

  input  logic [7:0]            gap_cycles,
  output logic [1:0]            grant,
  output logic [CNT_WIDTH-1:0]  frame_count_0,
  output logic [CNT_WIDTH-1:0]  frame_count_1,
  output logic                  busy
);

  arb_state_t state;
  logic       frame_end;
  logic       pick_p1;
  logic       gap_load;
  logic       gap_dec;
  logic       gap_done;

`ifndef TX_ARB_STRICT_PRIO_EN
  // 1 when port 1 completed the most recent frame
  logic       last_served;
`endif

  // Zero-latency pass-through; everything is held at zero outside GRANT,
  // which also covers reset because state is forced to IDLE asynchronously.
  always_comb begin
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = '0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    if (state == ST_GRANT) begin
      if (grant[PORT0]) begin
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tkeep   = s0_axis_tkeep;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tlast   = s0_axis_tlast;
        m_axis_tuser   = s0_axis_tuser;
        s0_axis_tready = m_axis_tready;
      end else if (grant[PORT1]) begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tkeep   = s1_axis_tkeep;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tlast   = s1_axis_tlast;
        m_axis_tuser   = s1_axis_tuser;
        s1_axis_tready = m_axis_tready;
      end
    end
  end

  assign frame_end = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  always_comb begin
`ifdef TX_ARB_STRICT_PRIO_EN
    pick_p1 = !s0_axis_tvalid;
`else
    // On a tie, serve whichever port did not finish the previous frame.
    pick_p1 = s1_axis_tvalid & (!s0_axis_tvalid | !last_served);
`endif
  end

  assign gap_load = (state == ST_GRANT) && frame_end && (gap_cycles != 8'd0);
  assign gap_dec  = (state == ST_GAP);

  tx_arb_gap_counter u_gap (
    .tx_clk   (tx_clk),
    .tx_rst   (tx_rst),
    .load     (gap_load),
    .load_val (gap_cycles),
    .dec      (gap_dec),
    .done     (gap_done)
  );

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state         <= ST_IDLE;
      grant         <= GRANT_NONE;
      busy          <= 1'b0;
      frame_count_0 <= '0;
      frame_count_1 <= '0;
`ifndef TX_ARB_STRICT_PRIO_EN
      last_served   <= 1'b1;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (s0_axis_tvalid || s1_axis_tvalid) begin
            state <= ST_GRANT;
            busy  <= 1'b1;
            grant <= pick_p1 ? GRANT_P1 : GRANT_P0;
          end
        end
        ST_GRANT: begin
          // Grant is only released on the tlast handshake, so a stalled MAC
          // or a requester dropping tvalid mid-frame keeps ownership.
          if (frame_end) begin
            grant <= GRANT_NONE;
            if (grant[PORT1]) begin
              frame_count_1 <= frame_count_1 + CNT_WIDTH'(1);
            end else begin
              frame_count_0 <= frame_count_0 + CNT_WIDTH'(1);
            end
`ifndef TX_ARB_STRICT_PRIO_EN
            last_served <= grant[PORT1];
`endif
            if (gap_cycles == 8'd0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= GRANT_NONE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
